// File: rtl/interleaver_commutator.sv
// Commutator and sequencer for a convolutional interleaver branch bank: acquires
// packet sync, strobes one branch per byte and merges the branch outputs.
module interleaver_commutator #(
   parameter int         NUM_BRANCH = 12,
   parameter int         BR_W       = 4,
   parameter int         FRAME_LEN  = 204,
   parameter logic [7:0] SYNC_BYTE  = 8'h47,
   parameter int         MISS_MAX   = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [7:0]              in_data,
   input  logic [8*NUM_BRANCH-1:0] br_data_in,
   output logic [NUM_BRANCH-1:0]   buf_en,
   output logic [7:0]              br_data_out,
   output logic                    out_valid,
   output logic [7:0]              out_data,
   output logic                    locked,
   output logic                    sync_lost
);

   localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int MISS_W = (MISS_MAX > 1) ? $clog2(MISS_MAX + 1) : 1;

   typedef enum logic [0:0] {
      ST_SEARCH  = 1'b0,
      ST_ALIGNED = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [BR_W-1:0]       ptr_q, ptr_d, ptr_inc;
   logic [BR_W-1:0]       sel_q, sel_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [MISS_W-1:0]     miss_q, miss_d;
   logic [NUM_BRANCH-1:0] buf_en_q, buf_en_d, ptr_hot;
   logic [7:0]            br_data_out_q, br_data_out_d;
   logic [7:0]            out_data_q, out_data_d;
   logic                  stb_q, stb_d;
   logic                  out_valid_q, out_valid_d;
   logic                  locked_q, locked_d;
   logic                  sync_lost_q, sync_lost_d;
   logic                  is_sync, accept, sync_slot, lose;
   logic [7:0]            br_masked [NUM_BRANCH];
   logic [7:0]            br_mux;
   logic                  unused_br0;

   assign is_sync   = (in_data == SYNC_BYTE);
   assign accept    = in_valid && ((state_q == ST_ALIGNED) || is_sync);
   assign sync_slot = (cnt_q == '0);
   assign lose      = in_valid && (state_q == ST_ALIGNED) && sync_slot && !is_sync
                      && (miss_q == MISS_W'(MISS_MAX - 1));
   assign ptr_inc   = (ptr_q == BR_W'(NUM_BRANCH - 1)) ? '0 : ptr_q + 1'b1;
   assign cnt_inc   = (cnt_q == CNT_W'(FRAME_LEN - 1)) ? '0 : cnt_q + 1'b1;

   // Branch 0 is the internal bypass: it never gets a strobe and its lane is ignored.
   assign unused_br0 = ^br_data_in[7:0];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BRANCH; gi++) begin : g_branch
         if (gi == 0) begin : g_bypass
            assign ptr_hot[gi]   = 1'b0;
            assign br_masked[gi] = 8'h00;
         end else begin : g_delay
            assign ptr_hot[gi]   = (ptr_q == BR_W'(gi));
            assign br_masked[gi] = (sel_q == BR_W'(gi)) ? br_data_in[8*gi +: 8] : 8'h00;
         end
      end
   endgenerate

   always_comb begin : mux_comb
      br_mux = 8'h00;
      for (int i = 0; i < NUM_BRANCH; i++) begin
         br_mux = br_mux | br_masked[i];
      end
   end

   // ---------------- FSM: state register / next state / outputs ----------------
   always_ff @(posedge clk) begin : state_reg
      if (reset) begin
         state_q <= ST_SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : next_state_comb
      state_d = state_q;
      case (state_q)
         ST_SEARCH:  if (in_valid && is_sync) state_d = ST_ALIGNED;
         ST_ALIGNED: if (lose) state_d = ST_SEARCH;
         default:    state_d = ST_SEARCH;
      endcase
   end

   always_comb begin : fsm_out_comb
      locked_d    = (state_d == ST_ALIGNED);
      sync_lost_d = lose;
   end

   // ---------------- Position and sync-miss tracking ----------------
   always_comb begin : counters_comb
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      miss_d = miss_q;
      if (accept) begin
         ptr_d = ptr_inc;
         cnt_d = cnt_inc;
         if (state_q == ST_SEARCH) begin
            miss_d = '0;
         end else if (sync_slot) begin
            miss_d = is_sync ? '0 : miss_q + 1'b1;
         end
      end
      // The triggering byte is still strobed below; only the position restarts.
      if (lose) begin
         ptr_d  = '0;
         cnt_d  = '0;
         miss_d = '0;
      end
   end

   // ---------------- Stage 1: strobe the selected branch ----------------
   always_comb begin : stage1_comb
      buf_en_d      = '0;
      br_data_out_d = br_data_out_q;
      sel_d         = sel_q;
      stb_d         = accept;
      if (accept) begin
         buf_en_d      = ptr_hot;
         br_data_out_d = in_data;
         sel_d         = ptr_q;
      end
   end

   // ---------------- Stage 2: merge branch outputs ----------------
   always_comb begin : stage2_comb
      out_valid_d = stb_q;
      out_data_d  = out_data_q;
      if (stb_q) begin
         out_data_d = (sel_q == '0) ? br_data_out_q : br_mux;
      end
   end

   always_ff @(posedge clk) begin : datapath_reg
      if (reset) begin
         ptr_q         <= '0;
         cnt_q         <= '0;
         miss_q        <= '0;
         sel_q         <= '0;
         buf_en_q      <= '0;
         br_data_out_q <= 8'h00;
         stb_q         <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= 8'h00;
         locked_q      <= 1'b0;
         sync_lost_q   <= 1'b0;
      end else begin
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         miss_q        <= miss_d;
         sel_q         <= sel_d;
         buf_en_q      <= buf_en_d;
         br_data_out_q <= br_data_out_d;
         stb_q         <= stb_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         locked_q      <= locked_d;
         sync_lost_q   <= sync_lost_d;
      end
   end

   assign buf_en      = buf_en_q;
   assign br_data_out = br_data_out_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign locked      = locked_q;
   assign sync_lost   = sync_lost_q;

endmodule

// File: tb/tb_interleaver_commutator.sv
// Randomized bench for interleaver_commutator: a branch-bank model drives br_data_in,
// a packet-level reference predicts every output and a monitor checks each cycle.
module tb_interleaver_commutator;

   localparam int         NB       = 12;
   localparam int         BR_W     = 4;
   localparam int         FRAME    = 204;
   localparam logic [7:0] SYNC     = 8'h47;
   localparam int         MISS_MAX = 3;
   localparam int         MAXD     = 17 * (NB - 1);

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic [7:0]      in_data;
   logic [8*NB-1:0] br_data_in;
   logic [NB-1:0]   buf_en;
   logic [7:0]      br_data_out;
   logic            out_valid;
   logic [7:0]      out_data;
   logic            locked;
   logic            sync_lost;

   interleaver_commutator #(
      .NUM_BRANCH (NB),
      .BR_W       (BR_W),
      .FRAME_LEN  (FRAME),
      .SYNC_BYTE  (SYNC),
      .MISS_MAX   (MISS_MAX)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .br_data_in  (br_data_in),
      .buf_en      (buf_en),
      .br_data_out (br_data_out),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .locked      (locked),
      .sync_lost   (sync_lost)
   );

   always #5 clk = ~clk;

   // Branch bank: branch j is a 17*j byte circular delay line; its output is the oldest byte.
   logic [7:0] dl [NB][MAXD];
   int         wp [NB];
   bit         bank_ready;
   logic [7:0] lane0;

   always @(posedge clk) begin
      if (!bank_ready) begin
         for (int j = 0; j < NB; j++) begin
            wp[j] <= 0;
            for (int i = 0; i < MAXD; i++) dl[j][i] <= 8'h00;
         end
         bank_ready <= 1'b1;
      end else begin
         for (int j = 1; j < NB; j++) begin
            if (buf_en[j]) begin
               dl[j][wp[j]] <= br_data_out;
               wp[j]        <= (wp[j] + 1 == 17 * j) ? 0 : wp[j] + 1;
            end
         end
      end
   end

   always_comb begin
      br_data_in       = '0;
      br_data_in[7:0]  = lane0;
      for (int j = 1; j < NB; j++) br_data_in[8*j +: 8] = dl[j][wp[j]];
   end

   // ---------------- Scoreboard and counters ----------------
   typedef struct {
      logic          locked;
      logic          lost;
      logic          ov;
      logic          rst;
      logic [NB-1:0] be;
   } stat_t;

   stat_t      st_q [$];
   logic [7:0] exp_q [$];
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- Reference model (packet-level) ----------------
   bit         m_aligned;
   int         m_pos;
   int         m_miss;
   bit         pend_v;
   logic [7:0] pend_d;
   logic [7:0] hist [NB][$];

   task automatic model_step(input bit r, input bit v, input logic [7:0] d);
      stat_t s;
      int    b;
      int    k;
      s.ov   = 1'b0;
      s.lost = 1'b0;
      s.be   = '0;
      s.rst  = r;
      if (pend_v) begin
         if (!r) begin
            exp_q.push_back(pend_d);
            s.ov = 1'b1;
         end
         pend_v = 1'b0;
      end
      if (r) begin
         m_aligned = 1'b0;
         m_pos     = 0;
         m_miss    = 0;
      end else if (v && (m_aligned || d == SYNC)) begin
         if (!m_aligned) begin
            m_aligned = 1'b1;
            m_miss    = 0;
         end else if (m_pos == 0) begin
            m_miss = (d == SYNC) ? 0 : m_miss + 1;
         end
         // Forney rule: branch b returns the byte it received 17*b visits earlier.
         b = m_pos % NB;
         hist[b].push_back(d);
         k = hist[b].size() - 1 - 17 * b;
         pend_d = (k >= 0) ? hist[b][k] : 8'h00;
         pend_v = 1'b1;
         if (b != 0) s.be[b] = 1'b1;
         m_pos = (m_pos + 1) % FRAME;
         if (m_miss == MISS_MAX) begin
            m_aligned = 1'b0;
            m_pos     = 0;
            m_miss    = 0;
            s.lost    = 1'b1;
         end
      end
      s.locked = m_aligned;
      st_q.push_back(s);
   endtask

   // ---------------- Monitor ----------------
   stat_t mon_s;

   always @(negedge clk) begin
      if (st_q.size() > 0) begin
         mon_s = st_q.pop_front();
         chk("locked", 32'(locked), 32'(mon_s.locked));
         chk("sync_lost", 32'(sync_lost), 32'(mon_s.lost));
         chk("buf_en", 32'(buf_en), 32'(mon_s.be));
         chk("out_valid", 32'(out_valid), 32'(mon_s.ov));
         if (mon_s.rst) begin
            chk("rst_br_data_out", 32'(br_data_out), 32'h0);
            chk("rst_out_data", 32'(out_data), 32'h0);
         end
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- Stimulus ----------------
   task automatic cyc(input bit r, input bit v, input logic [7:0] d);
      reset    = r;
      in_valid = v;
      in_data  = d;
      lane0    = 8'($urandom);
      @(posedge clk);
      #1;
      model_step(r, v, d);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit gaps);
      if (gaps && $urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 3)) cyc(1'b0, 1'b0, 8'($urandom));
      end
      cyc(1'b0, 1'b1, d);
   endtask

   task automatic send_pkt(input logic [7:0] sync, input bit gaps, input int n);
      send_byte(sync, gaps);
      for (int i = 1; i < n; i++) send_byte(8'($urandom), gaps);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      lane0    = 8'h00;

      // Reset, then idle
      repeat (2) cyc(1'b1, 1'b0, 8'h00);
      repeat (10) cyc(1'b0, 1'b0, 8'h00);

      // Junk, then acquisition packet with counting payload
      repeat (5) cyc(1'b0, 1'b1, 8'h00);
      send_byte(SYNC, 1'b0);
      for (int i = 1; i < FRAME; i++) send_byte(8'(i), 1'b0);

      // Gap-free and gapped random packets
      repeat (2) send_pkt(SYNC, 1'b0, FRAME);
      repeat (8) send_pkt(SYNC, 1'b1, FRAME);

      // Three corrupted sync bytes in a row, then junk and re-lock
      repeat (2) send_pkt(SYNC ^ 8'($urandom_range(1, 255)), 1'b1, FRAME);
      send_byte(SYNC ^ 8'($urandom_range(1, 255)), 1'b0);
      repeat (10) cyc(1'b0, 1'b1, 8'h00);
      repeat (2) send_pkt(SYNC, 1'b1, FRAME);

      // Reset mid-packet right behind a valid byte, then SEARCH resumes
      send_pkt(SYNC, 1'b0, 100);
      cyc(1'b1, 1'b0, 8'h00);
      repeat (20) cyc(1'b0, 1'b1, 8'($urandom_range(0, 8'h46)));
      send_pkt(SYNC, 1'b1, FRAME);

      // Reset coinciding with a valid sync byte
      send_pkt(SYNC, 1'b0, 30);
      cyc(1'b1, 1'b1, SYNC);
      repeat (6) cyc(1'b0, 1'b0, 8'h00);

      @(negedge clk);
      #1;
      chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
      chk("status_drain", 32'(st_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/interleaver_commutator.md
Name: interleaver_commutator

Overview:
- Sequencing controller for the byte-wide convolutional interleaver branch bank. The bank holds branches 1..NUM_BRANCH-1, each a delay line of j*17 bytes built from 8-bit delay-line buffers with buf_en strobes.
- Finds packet sync, then rotates an input commutator over the branches one byte at a time. Drives a one-hot buf_en to the selected branch and merges the branch outputs back into one output byte stream.
- Branch 0 has zero delay and is implemented inside this block. Packet sync is monitored continuously, and alignment is dropped after repeated misses.

Parameters:
- NUM_BRANCH, 12, number of commutator branches; branch 0 is internal bypass.
- BR_W, 4, width of the branch pointer; must satisfy 2^BR_W >= NUM_BRANCH.
- FRAME_LEN, 204, bytes per packet; must be a multiple of NUM_BRANCH.
- SYNC_BYTE, 8'h47, packet sync pattern.
- MISS_MAX, 3, number of consecutive sync misses that causes loss of alignment.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data is valid this cycle; there is no backpressure.
- in_data, input, 8, input byte.
- br_data_in, input, 8*NUM_BRANCH, branch delay-line outputs; slice j = branch j; slice 0 is ignored.
- buf_en, output, NUM_BRANCH, one-hot shift strobe per branch; bit 0 is unused and always 0.
- br_data_out, output, 8, byte broadcast to all branch inputs.
- out_valid, output, 1, out_data is valid.
- out_data, output, 8, interleaved byte.
- locked, output, 1, block is in ALIGNED state.
- sync_lost, output, 1, one-cycle pulse on loss of alignment.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - buf_en = 0, br_data_out = 0, out_valid = 0, out_data = 0, locked = 0, sync_lost = 0.
  - Branch pointer = 0, byte counter = 0, miss counter = 0, state = SEARCH.
  - Reset asserted mid-stream takes effect at the next edge and discards all in-flight bytes. Branch delay-line contents are not cleared by this block.
- States: SEARCH and ALIGNED.
- SEARCH:
  - Bytes with in_valid are discarded and buf_en stays 0.
  - When in_valid=1 and in_data==SYNC_BYTE: go to ALIGNED. That byte is processed as byte 0 of a packet on branch 0, using the ALIGNED rules in the same cycle. Byte counter becomes 1 and branch pointer becomes 1.
- ALIGNED, for each cycle with in_valid=1:
  - Stage 1 (edge n+1): br_data_out <= in_data; buf_en <= one-hot(ptr) if ptr != 0, else 0; sel_r <= ptr.
  - ptr increments and wraps from NUM_BRANCH-1 to 0.
  - Byte counter increments and wraps from FRAME_LEN-1 to 0.
- ALIGNED, for each cycle with in_valid=0:
  - buf_en <= 0; ptr, byte counter and sel_r hold.
  - A valid gap never advances the commutator.
- Stage 2 (edge n+2), when the stage-1 strobe was valid:
  - If sel_r == 0: out_data <= br_data_out.
  - Otherwise: out_data <= br_data_in[sel_r], sampled after the branch has shifted.
  - out_valid <= 1. Otherwise out_valid <= 0.
- Latency: in_valid at cycle n gives out_valid at cycle n+2, constant. Throughput is 1 byte per cycle.
- Sync check, in ALIGNED, on a valid byte with byte counter == 0:
  - in_data == SYNC_BYTE: miss counter <= 0.
  - Otherwise: miss counter increments. When the count reaches MISS_MAX, at the same edge: state <= SEARCH, locked <= 0, sync_lost pulses for 1 cycle, ptr <= 0, byte counter <= 0.
  - The mismatching byte that triggers the loss is still processed (strobed and output).
  - Bytes already in the pipeline drain normally: out_valid may assert for up to 2 cycles after loss.
- Invariant: ptr == byte counter mod NUM_BRANCH. Every sync byte uses branch 0.
- locked is registered and is 1 from the edge that enters ALIGNED.

Test Plan:
- Reset then idle: reset held 2 cycles, then in_valid=0 for 10 cycles -> all outputs stay 0, locked=0.
- Sync acquisition: feed 5 junk bytes (0x00), then 0x47 and 203 counting bytes -> junk produces no buf_en; locked=1 at the 0x47 edge; buf_en sequence 000,002,004,...,800 (hex) repeating per byte; out_valid exactly 2 cycles after each in_valid.
- Branch 0 bypass: the 0x47 byte -> out_data=0x47 two cycles later, independent of br_data_in.
- Mux check: model branch j as a 17*j-byte delay line, stream 3 packets -> out_data equals the golden Forney interleaver output byte-for-byte.
- Valid gaps: insert random in_valid=0 cycles -> buf_en=0 during gaps, ptr does not advance, and output matches the gap-free reference.
- Sync loss and reset: corrupt sync on 3 consecutive packets -> sync_lost pulses once at the 3rd corrupted sync byte, locked=0, then re-lock on the next 0x47. Separately, assert reset mid-packet -> outputs 0 next cycle and SEARCH resumes.
